// File: rtl/waveform_combiner_if.sv
// Sample-request / result bundle between a sequencer and the waveform combiner.
interface waveform_combiner_if;
  logic       start;
  logic [3:0] voice_en;
  logic [7:0] wave0;
  logic [7:0] wave1;
  logic [7:0] wave2;
  logic [7:0] wave3;
  logic [8:0] comb_waveform;
  logic       ready;
  logic       busy;
  logic       overrun;

  modport master (
    output start, voice_en, wave0, wave1, wave2, wave3,
    input  comb_waveform, ready, busy, overrun
  );

  modport slave (
    input  start, voice_en, wave0, wave1, wave2, wave3,
    output comb_waveform, ready, busy, overrun
  );
endinterface

// File: rtl/waveform_combiner.sv
// Averages the enabled oscillator voices into one PWM duty sample.
// Fixed 15-edge latency from accepted start to ready, regardless of voice count.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; snapshot inputs on accept
// ACCUM  | one voice per cycle: sum enabled snapshots, count them
// DIV    | 10 restoring-division steps of sum / count, MSB first
// OUT    | publish quotient (255 maps to 256 full scale), pulse ready
module waveform_combiner (
  input logic                 clk,
  input logic                 n_rst,
  waveform_combiner_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DIV   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] wave_q, wave_d;
  logic [3:0]      en_q, en_d;
  // sum_q doubles as the dividend/quotient shift register during DIV
  logic [9:0]      sum_q, sum_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      div_cnt_q, div_cnt_d;
  // remainder is always below the divisor (<= 4), so 3 bits suffice
  logic [2:0]      rem_q, rem_d;
  logic [8:0]      comb_q, comb_d;
  logic            ready_q, ready_d;
  logic            overrun_q, overrun_d;

  logic [3:0]      rem_sh;
  logic [7:0]      quot;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      wave_q    <= '0;
      en_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      div_cnt_q <= '0;
      rem_q     <= '0;
      comb_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wave_q    <= wave_d;
      en_q      <= en_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      div_cnt_q <= div_cnt_d;
      rem_q     <= rem_d;
      comb_q    <= comb_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state, datapath and output pulse logic
  always_comb begin
    state_d   = state_q;
    wave_d    = wave_q;
    en_d      = en_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    comb_d    = comb_q;
    ready_d   = 1'b0;
    overrun_d = bus.start && (state_q != S_IDLE);
    rem_sh    = {rem_q, sum_q[9]};
    quot      = (cnt_q == 3'd0) ? 8'd0 : sum_q[7:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          wave_d    = {bus.wave3, bus.wave2, bus.wave1, bus.wave0};
          en_d      = bus.voice_en;
          sum_d     = '0;
          cnt_d     = '0;
          idx_d     = '0;
          rem_d     = '0;
          div_cnt_d = 4'd9;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (en_q[idx_q]) begin
          sum_d = sum_q + {2'b00, wave_q[idx_q]};
          cnt_d = cnt_q + 3'd1;
        end
        idx_d     = idx_q + 2'd1;
        rem_d     = '0;
        div_cnt_d = 4'd9;
        if (idx_q == 2'd3) state_d = S_DIV;
      end
      S_DIV: begin
        // count of 0 yields all-ones here; forced to 0 in OUT
        if (rem_sh >= {1'b0, cnt_q}) begin
          rem_d = 3'(rem_sh - {1'b0, cnt_q});
          sum_d = {sum_q[8:0], 1'b1};
        end else begin
          rem_d = rem_sh[2:0];
          sum_d = {sum_q[8:0], 1'b0};
        end
        if (div_cnt_q == 4'd0) state_d = S_OUT;
        else                   div_cnt_d = div_cnt_q - 4'd1;
      end
      S_OUT: begin
        comb_d  = (quot == 8'd255) ? 9'd256 : {1'b0, quot};
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.comb_waveform = comb_q;
  assign bus.ready         = ready_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_waveform_combiner.sv
module tb_waveform_combiner;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  waveform_combiner_if bus();

  waveform_combiner dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int last_comb = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: mean of the enabled voices, truncated; no voices -> 0; 255 -> 256.
  function automatic int model(input logic [3:0] en, input int w0, input int w1,
                               input int w2, input int w3);
    int w[4];
    int sum;
    int n;
    int q;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    sum = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        sum += w[i];
        n++;
      end
    end
    if (n == 0) return 0;
    q = sum / n;
    return (q == 255) ? 256 : q;
  endfunction

  task automatic scramble_inputs();
    bus.wave0    = 8'($urandom);
    bus.wave1    = 8'($urandom);
    bus.wave2    = 8'($urandom);
    bus.wave3    = 8'($urandom);
    bus.voice_en = 4'($urandom);
  endtask

  // One sample: start accepted at E0, then edges E1..E15 checked cycle by cycle.
  // glitch: edge at which start is re-pulsed with new inputs (0 = none).
  // abort_at: edge after which reset is asserted (0 = none).
  task automatic run(input logic [3:0] en, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d,
                     input int glitch, input int abort_at);
    int expv;
    expv = model(en, a, b, c, d);
    bus.voice_en = en;
    bus.wave0 = a; bus.wave1 = b; bus.wave2 = c; bus.wave3 = d;
    bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("busy_e0", bus.busy, 1);
    chk("ready_e0", bus.ready, 0);
    chk("overrun_e0", bus.overrun, 0);
    scramble_inputs();
    for (int k = 1; k <= 15; k++) begin
      if (k == glitch) begin
        bus.start = 1'b1;
        scramble_inputs();
      end
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      if (k == abort_at) begin
        n_rst = 1'b0;
        #1;
        chk("abort_comb", bus.comb_waveform, 0);
        chk("abort_ready", bus.ready, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_overrun", bus.overrun, 0);
        last_comb = 0;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_ready", bus.ready, 0);
          chk("abort_idle", bus.busy, 0);
        end
        n_rst = 1'b1;
        return;
      end
      chk("ready", bus.ready, (k == 15) ? 1 : 0);
      chk("busy", bus.busy, (k < 15) ? 1 : 0);
      chk("overrun", bus.overrun, (k == glitch) ? 1 : 0);
      if (k < 15) chk("comb_hold", bus.comb_waveform, 16'(last_comb));
    end
    chk("comb", bus.comb_waveform, 16'(expv));
    last_comb = expv;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.voice_en = '0;
    bus.wave0 = '0; bus.wave1 = '0; bus.wave2 = '0; bus.wave3 = '0;
    #2;
    chk("rst_comb", bus.comb_waveform, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    run(4'b1111, 200, 200, 200, 200, 0, 0);
    run(4'b1111, 255, 255, 255, 255, 0, 0);
    run(4'b0101, 10, 99, 21, 77, 0, 0);
    run(4'b0111, 100, 50, 1, 200, 0, 0);
    run(4'b0000, 12, 34, 56, 78, 0, 0);
    run(4'b1011, 90, 80, 70, 60, 7, 0);
    run(4'b0001, 255, 0, 0, 0, 15, 0);
    run(4'b0101, 10, 0, 21, 0, 0, 9);
    run(4'b0101, 10, 0, 21, 0, 0, 0);
    // back-to-back: next start issued right at the ready cycle
    run(4'b1000, 0, 0, 0, 137, 0, 0);
    run(4'b1100, 1, 2, 254, 255, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int g;
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
      run(4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), g, 0);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/waveform_combiner.md
WAVEFORM_COMBINER -- requirements
Module: waveform_combiner

Interface
Parameters: none.
REQ-001 SHALL have port: clk  input  1  system clock (10 kHz sample-domain clock); all logic on rising edge.
REQ-002 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle strobe requesting a new combined sample.
REQ-004 SHALL have port: voice_en  input  4  per-voice active bits; bit i enables wave_i.
REQ-005 SHALL have ports: wave0, wave1, wave2, wave3  input  8 each  unsigned oscillator samples.
REQ-006 SHALL have port: comb_waveform  output  9  registered combined sample, 0..256, feeds the PWM duty input.
REQ-007 SHALL have port: ready  output  1  registered one-cycle pulse; comb_waveform is valid and newly updated.
REQ-008 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 SHALL have port: overrun  output  1  registered one-cycle pulse; start was dropped.

Function
REQ-010 SHALL implement FSM states IDLE, ACCUM, DIV, OUT.
REQ-011 Edge E0, IDLE with start=1: snapshot wave0..3 and voice_en into internal registers; clear sum (10 bit) and active count (3 bit); set voice index 0; go to ACCUM.
REQ-012 Input changes after E0 SHALL NOT affect the result in progress.
REQ-013 ACCUM, edges E1..E4: one voice per edge, index 0..3; if its enable bit is set, add its snapshot to sum and increment count; go to DIV after index 3.
REQ-014 Sum SHALL be 10 bits (max 4*255=1020, no overflow); count range 0..4.
REQ-015 DIV, edges E5..E14: exactly 10 iterations of restoring division, sum / count, MSB first; quotient 8 bits used, remainder discarded (truncation); go to OUT after the 10th iteration.
REQ-016 Count=0: division result SHALL be forced to 0; DIV still takes 10 cycles (fixed latency).
REQ-017 OUT, edge E15: comb_waveform <= quotient, except quotient 255 -> 256 (full-scale duty); ready <= 1; go to IDLE.
REQ-018 ready SHALL be high only for the cycle following E15 and low otherwise; total latency from the start-sampling edge to ready rising is 15 edges.
REQ-019 comb_waveform SHALL hold its value between updates.
REQ-020 start sampled in ACCUM, DIV or OUT SHALL be ignored; overrun SHALL pulse high for one cycle on the following cycle; the in-flight result SHALL be unaffected.
REQ-021 start sampled in IDLE (earliest E16 after a previous start) SHALL be accepted; back-to-back throughput is one sample per 16 cycles.
REQ-022 busy SHALL be decoded from state (combinational), low only in IDLE.

Reset
REQ-023 n_rst=0 SHALL immediately force: state IDLE, comb_waveform 0, ready 0, overrun 0, busy 0, sum/count/index/divider registers 0.
REQ-024 Reset asserted mid-operation SHALL abort it; no ready pulse for the aborted sample; the first start after release SHALL behave as from power-up.

Verification
REQ-025 voice_en=1111, all waves 200, start at E0 -> ready at E15, comb_waveform=200, busy high E0..E15.
REQ-026 voice_en=1111, all waves 255 -> comb_waveform=256; voice_en=0101, wave0=10, wave2=21 -> 15 (truncated).
REQ-027 voice_en=0111, waves 100,50,1 -> 151/3 -> comb_waveform=50; voice_en=0000 -> comb_waveform=0, ready still at E15.
REQ-028 start at E0, waves changed and start re-pulsed at E7 -> overrun pulse after E7, result from E0 snapshot only, a single ready at E15.
REQ-029 n_rst low during DIV (E9) -> all outputs 0 at once, no ready; start after release -> correct result 15 edges later.
REQ-030 Back-to-back starts at E0 and E16 -> two ready pulses at E15 and E31, no overrun.
